// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
// Mode encoding, FSM state type and counter-width helper.
package addsub_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Digit counter width: $clog2(n), never below 1 bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/addsub_digit_serial_rca.sv
// rca_digit: combinational DIGIT-bit ripple-carry adder.
// Ports: a, b (DIGIT), cin -> sum (DIGIT), cout.
module rca_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout
);

   logic [DIGIT:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign sum[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[DIGIT];

endmodule

// File: rtl/addsub_digit_serial.sv
// Digit-serial add/sub, DIGIT bits per cycle, LSB slice first.
// In: clk, rst_n, start, mode, a, b. Out: busy, done, result, carry, overflow.
module addsub_digit_serial
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = cnt_width(N);

   state_t           state, state_nx;
   logic [WIDTH-1:0] opa, opb, work, work_nx;
   logic [CW-1:0]    cnt;
   logic             cf, mode_q, a_msb, b_msb;
   logic [DIGIT-1:0] sum;
   logic             cout, accept, last, sub;

   assign sub    = (mode == MODE_SUB);
   assign accept = start && (state != RUN);
   assign last   = (cnt == CW'(N - 1));

   rca_digit #(.DIGIT(DIGIT)) u_rca (
      .a    (opa[DIGIT-1:0]),
      .b    (opb[DIGIT-1:0]),
      .cin  (cf),
      .sum  (sum),
      .cout (cout)
   );

   // New slice enters at the top; after N shifts slice 0 sits at the LSB.
   assign work_nx = (work >> DIGIT) | (WIDTH'(sum) << (WIDTH - DIGIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last)  state_nx = DONE;
         DONE:    state_nx = start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa      <= '0;
         opb      <= '0;
         work     <= '0;
         cnt      <= '0;
         cf       <= 1'b0;
         mode_q   <= MODE_ADD;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         result   <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         opa    <= a;
         opb    <= b ^ {WIDTH{sub}};
         mode_q <= mode;
         cnt    <= '0;
         cf     <= sub;
         a_msb  <= a[WIDTH-1];
         b_msb  <= b[WIDTH-1] ^ sub;
      end else if (state == RUN) begin
         opa  <= opa >> DIGIT;
         opb  <= opb >> DIGIT;
         work <= work_nx;
         cf   <= cout;
         cnt  <= cnt + 1'b1;
         if (last) begin
            result   <= work_nx;
            // Subtract reports borrow, the inverse of the carry-out.
            carry    <= cout ^ mode_q;
            overflow <= (a_msb == b_msb) &&
                        (work_nx[WIDTH-1] != a_msb);
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_addsub_digit_serial.sv
// Bench for addsub_digit_serial: 16/4, 8/1 and 8/8 instances
// checked against an arithmetic a+/-b reference model.
module tb_addsub_digit_serial;
   import addsub_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   logic        start16 = 0, mode16 = 0;
   logic [15:0] a16 = 0, b16 = 0, res16;
   logic        busy16, done16, c16, ov16;

   logic        start8 = 0, mode8 = 0;
   logic [7:0]  a8 = 0, b8 = 0, res8s, res8p;
   logic        busy8s, done8s, c8s, ov8s;
   logic        busy8p, done8p, c8p, ov8p;

   addsub_digit_serial #(.WIDTH(16), .DIGIT(4)) u16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .mode(mode16),
      .a(a16), .b(b16), .busy(busy16), .done(done16),
      .result(res16), .carry(c16), .overflow(ov16));

   addsub_digit_serial #(.WIDTH(8), .DIGIT(1)) u8s (
      .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8),
      .a(a8), .b(b8), .busy(busy8s), .done(done8s),
      .result(res8s), .carry(c8s), .overflow(ov8s));

   addsub_digit_serial #(.WIDTH(8), .DIGIT(8)) u8p (
      .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8),
      .a(a8), .b(b8), .busy(busy8p), .done(done8p),
      .result(res8p), .carry(c8p), .overflow(ov8p));

   // {overflow, carry/borrow, result} from plain integer arithmetic.
   function automatic logic [17:0] ref_model(input int w, input logic m,
                                             input logic [15:0] x,
                                             input logic [15:0] y);
      int ux, uy, sx, sy, r, full, half;
      logic [15:0] res;
      logic c, ov;
      full = 1 << w;
      half = full / 2;
      ux = int'(x);
      uy = int'(y);
      if (m == MODE_ADD) begin
         r = ux + uy;
         c = (r >= full);
      end else begin
         r = ux - uy;
         c = (ux < uy);
      end
      res = 16'(((r % full) + full) % full);
      sx = (ux >= half) ? ux - full : ux;
      sy = (uy >= half) ? uy - full : uy;
      r = (m == MODE_SUB) ? sx - sy : sx + sy;
      ov = (r < -half) || (r >= half);
      return {ov, c, res};
   endfunction

   task automatic run16(input logic m, input logic [15:0] x,
                        input logic [15:0] y, output int lat);
      @(negedge clk);
      start16 = 1; mode16 = m; a16 = x; b16 = y;
      @(posedge clk); #1;
      start16 = 0; mode16 = ~m;
      a16 = 16'($urandom); b16 = 16'($urandom);
      lat = 0;
      while (done16 !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run8(input logic m, input logic [7:0] x,
                       input logic [7:0] y,
                       output logic [9:0] gs, output logic [9:0] gp,
                       output int ls, output int lp);
      int n;
      @(negedge clk);
      start8 = 1; mode8 = m; a8 = x; b8 = y;
      @(posedge clk); #1;
      start8 = 0; mode8 = ~m;
      a8 = 8'($urandom); b8 = 8'($urandom);
      ls = -1; lp = -1; gs = '0; gp = '0; n = 0;
      while ((ls < 0 || lp < 0) && n <= 20) begin
         if (done8s === 1'b1 && ls < 0) begin
            ls = n; gs = {ov8s, c8s, res8s};
         end
         if (done8p === 1'b1 && lp < 0) begin
            lp = n; gp = {ov8p, c8p, res8p};
         end
         if (ls < 0 || lp < 0) begin
            @(posedge clk); #1;
         end
         n++;
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({busy16, done16, res16, c16, ov16} !== 19'd0) begin
         miscompares++;
         $display("FAIL reset16: got %h want 0",
                  {busy16, done16, res16, c16, ov16});
      end
      vectors++;
      if ({busy8s, done8s, res8s, c8s, ov8s} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset8s: got %h want 0",
                  {busy8s, done8s, res8s, c8s, ov8s});
      end
      vectors++;
      if ({busy8p, done8p, res8p, c8p, ov8p} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset8p: got %h want 0",
                  {busy8p, done8p, res8p, c8p, ov8p});
      end
      @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;
      vectors++;
      if (busy16 !== 1'b0 || done16 !== 1'b0) begin
         miscompares++;
         $display("FAIL idle16: got busy=%b done=%b want 0 0",
                  busy16, done16);
      end
   endtask

   task automatic test_directed();
      logic [15:0] ta[4] = '{16'h1234, 16'hFFFF, 16'h0005, 16'h8000};
      logic [15:0] tb[4] = '{16'h0FFF, 16'h0001, 16'h0007, 16'h0001};
      logic        tm[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [15:0] er[4] = '{16'h2233, 16'h0000, 16'hFFFE, 16'h7FFF};
      logic        ec[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic        eo[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      int lat;
      for (int i = 0; i < 4; i++) begin
         run16(tm[i], ta[i], tb[i], lat);
         vectors++;
         if (lat !== 4) begin
            miscompares++;
            $display("FAIL dir%0d latency: got %0d want 4", i, lat);
         end
         vectors++;
         if (res16 !== er[i]) begin
            miscompares++;
            $display("FAIL dir%0d result: got %h want %h",
                     i, res16, er[i]);
         end
         vectors++;
         if (c16 !== ec[i]) begin
            miscompares++;
            $display("FAIL dir%0d carry: got %b want %b", i, c16, ec[i]);
         end
         vectors++;
         if (ov16 !== eo[i]) begin
            miscompares++;
            $display("FAIL dir%0d overflow: got %b want %b",
                     i, ov16, eo[i]);
         end
         vectors++;
         if (busy16 !== 1'b0) begin
            miscompares++;
            $display("FAIL dir%0d busy_at_done: got %b want 0", i, busy16);
         end
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      @(negedge clk);
      start16 = 1; mode16 = MODE_ADD; a16 = 16'h1234; b16 = 16'h0FFF;
      @(posedge clk); #1;
      start16 = 0; mode16 = MODE_SUB; a16 = 16'hFFFF; b16 = 16'h0001;
      @(negedge clk);
      start16 = 1;
      @(posedge clk); #1;
      start16 = 0;
      lat = 1;
      while (done16 !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      vectors++;
      if (lat !== 4) begin
         miscompares++;
         $display("FAIL ignore latency: got %0d want 4", lat);
      end
      vectors++;
      if (res16 !== 16'h2233 || c16 !== 1'b0) begin
         miscompares++;
         $display("FAIL ignore result: got %h/%b want 2233/0", res16, c16);
      end
      @(posedge clk); #1;
      vectors++;
      if (busy16 !== 1'b0 || done16 !== 1'b0) begin
         miscompares++;
         $display("FAIL ignore requeue: got busy=%b done=%b want 0 0",
                  busy16, done16);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic seen;
      run16(MODE_ADD, 16'h1234, 16'h0FFF, lat);
      @(negedge clk);
      start16 = 1; mode16 = MODE_ADD; a16 = 16'hFFFF; b16 = 16'h0001;
      @(posedge clk); #1;
      start16 = 0;
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      vectors++;
      if ({busy16, done16, res16, c16, ov16} !== 19'd0) begin
         miscompares++;
         $display("FAIL midreset clear: got %h want 0",
                  {busy16, done16, res16, c16, ov16});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (done16 === 1'b1 || busy16 === 1'b1) seen = 1;
      end
      vectors++;
      if (seen !== 1'b0 || res16 !== 16'h0) begin
         miscompares++;
         $display("FAIL midreset resume: got act=%b res=%h want 0 0000",
                  seen, res16);
      end
   endtask

   task automatic test_back_to_back();
      logic [17:0] expq[$];
      logic [17:0] e;
      logic [15:0] x, y;
      logic m;
      int last_done, waitc;
      @(negedge clk);
      x = 16'($urandom); y = 16'($urandom); m = 1'($urandom);
      start16 = 1; mode16 = m; a16 = x; b16 = y;
      expq.push_back(ref_model(16, m, x, y));
      @(posedge clk); #1;
      last_done = -1;
      for (int i = 0; i < 6; i++) begin
         x = 16'($urandom); y = 16'($urandom); m = 1'($urandom);
         mode16 = m; a16 = x; b16 = y;
         expq.push_back(ref_model(16, m, x, y));
         waitc = 0;
         while (done16 !== 1'b1 && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
         end
         if (i == 5) start16 = 0;
         e = expq.pop_front();
         vectors++;
         if ({ov16, c16, res16} !== e) begin
            miscompares++;
            $display("FAIL b2b%0d value: got %h want %h",
                     i, {ov16, c16, res16}, e);
         end
         if (last_done >= 0) begin
            vectors++;
            if (cyc - last_done !== 5) begin
               miscompares++;
               $display("FAIL b2b%0d interval: got %0d want 5",
                        i, cyc - last_done);
            end
         end
         last_done = cyc;
         if (i < 5) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      vectors++;
      if (busy16 !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b stop: got busy=%b want 0", busy16);
      end
   endtask

   task automatic test_random16();
      logic [15:0] x, y;
      logic m;
      logic [17:0] e;
      int lat;
      for (int i = 0; i < 150; i++) begin
         x = 16'($urandom); y = 16'($urandom); m = 1'($urandom);
         e = ref_model(16, m, x, y);
         run16(m, x, y, lat);
         vectors++;
         if (lat !== 4 || {ov16, c16, res16} !== e) begin
            miscompares++;
            $display("FAIL rnd16 %h%s%h: got %h lat %0d want %h lat 4",
                     x, m ? "-" : "+", y, {ov16, c16, res16}, lat, e);
         end
      end
   endtask

   task automatic test_sweep8();
      logic [7:0] corner[6] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55};
      logic [7:0] x, y;
      logic m;
      logic [17:0] e;
      logic [9:0] gs, gp, ev;
      int ls, lp;
      for (int k = 0; k < 72 + 3000; k++) begin
         if (k < 72) begin
            x = corner[k % 6]; y = corner[(k / 6) % 6]; m = 1'(k / 36);
         end else begin
            x = 8'($urandom); y = 8'($urandom); m = 1'($urandom);
         end
         e = ref_model(8, m, {8'h00, x}, {8'h00, y});
         ev = {e[17], e[16], e[7:0]};
         run8(m, x, y, gs, gp, ls, lp);
         vectors++;
         if (ls !== 8 || gs !== ev) begin
            miscompares++;
            $display("FAIL sw8d1 %h%s%h: got %h lat %0d want %h lat 8",
                     x, m ? "-" : "+", y, gs, ls, ev);
         end
         vectors++;
         if (lp !== 1 || gp !== ev) begin
            miscompares++;
            $display("FAIL sw8d8 %h%s%h: got %h lat %0d want %h lat 1",
                     x, m ? "-" : "+", y, gp, lp, ev);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_random16();
      test_sweep8();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
